// File: rtl/har_pkg.sv
// Shared types and constants for the har classifier and its feature loader.
// Optional length checking in the loader is enabled with HAR_LOADER_LEN_CHECK_EN.
package har_pkg;

    localparam int unsigned HAR_IMG_SIZE    = 95;
    localparam int unsigned HAR_M           = 15;
    localparam int unsigned HAR_NUM_CLASSES = 6;

    typedef enum logic [1:0] {
        StFill,
        StHold,
        StDrain
    } har_state_e;

    // Clamp a wide signed value to the signed (m+1)-bit range.
    function automatic logic signed [63:0] har_saturate(input logic signed [63:0] v,
                                                        input int unsigned       m);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< m) - 64'sd1;
        lo = -(64'sd1 <<< m);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/har_sat_shift.sv
// Combinational arithmetic right shift followed by a clamp to the signed (M+1)-bit range.
// sat flags that the clamp changed the value.
module har_sat_shift
    import har_pkg::*;
#(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned M     = HAR_M,
    parameter int unsigned SHIFT = 8
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [M:0]      dout,
    output logic                   sat
);

    logic signed [63:0] wide;
    logic signed [63:0] shifted;
    logic signed [63:0] clamped;

    always_comb begin
        wide    = {{(64 - IN_W){din[IN_W-1]}}, din};
        shifted = wide >>> SHIFT;
        clamped = har_saturate(shifted, M);
        dout    = clamped[M:0];
        sat     = (clamped != shifted);
    end

endmodule

// File: rtl/har_feature_loader.sv
// Streaming loader: quantizes raw samples and assembles a frozen IMG_SIZE-element frame for har.
// Define HAR_LOADER_LEN_CHECK_EN to check s_last framing (adds the DRAIN state and frame_err).
module har_feature_loader
    import har_pkg::*;
#(
    parameter int unsigned IMG_SIZE = HAR_IMG_SIZE,
    parameter int unsigned M        = HAR_M,
    parameter int unsigned IN_W     = 24,
    parameter int unsigned SHIFT    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_data,
    input  logic                   s_last,
    output logic signed [M:0]      image [IMG_SIZE],
    output logic                   V_valid,
    input  logic                   v_ack,
    output logic [7:0]             sat_cnt,
    output logic                   frame_err
);

    localparam int unsigned IdxW = $clog2(IMG_SIZE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(IMG_SIZE - 1);

    har_state_e            state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [7:0]            sat_q, sat_d;
    logic signed [M:0]     image_q [IMG_SIZE];
    logic signed [M:0]     smp;
    logic                  smp_sat;
    logic                  accept;
    logic                  wr_en;

    har_sat_shift #(
        .IN_W  (IN_W),
        .M     (M),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .din  (s_data),
        .dout (smp),
        .sat  (smp_sat)
    );

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(IMG_SIZE); i++) begin
                image_q[i] <= '0;
            end
        end else if (wr_en) begin
            image_q[idx_q] <= smp;
        end
    end

`ifdef HAR_LOADER_LEN_CHECK_EN
    logic err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign frame_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        wr_en   = 1'b0;
`ifdef HAR_LOADER_LEN_CHECK_EN
        err_d   = 1'b0;
`endif
        if (clear) begin
            state_d = StFill;
            idx_d   = '0;
            sat_d   = '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + IdxW'(1);
                        if (smp_sat && sat_q != 8'hFF) begin
                            sat_d = sat_q + 8'd1;
                        end
`ifdef HAR_LOADER_LEN_CHECK_EN
                        if (idx_q == LastIdx) begin
                            idx_d = '0;
                            if (s_last) begin
                                state_d = StHold;
                            end else begin
                                err_d   = 1'b1;
                                sat_d   = '0;
                                state_d = StDrain;
                            end
                        end else if (s_last) begin
                            // Early end of frame: drop what was collected and restart.
                            err_d = 1'b1;
                            idx_d = '0;
                            sat_d = '0;
                        end
`else
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StHold;
                        end
`endif
                    end
                end
                StHold: begin
                    if (v_ack) begin
                        state_d = StFill;
                        idx_d   = '0;
                        sat_d   = '0;
                    end
                end
                StDrain: begin
                    if (accept && s_last) begin
                        state_d = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    // Gating with rst keeps s_ready low throughout reset and high as soon as it is released.
    always_comb begin
        s_ready = rst && (state_q != StHold);
        V_valid = (state_q == StHold);
        sat_cnt = sat_q;
    end

    assign image = image_q;

endmodule

// File: tb/tb_har_feature_loader.sv
// Self-checking bench for har_feature_loader: vector table, reference model and corner sequences.
// A second instance with a smaller shift exercises the clamp and sat_cnt paths.
module tb_har_feature_loader;
    import har_pkg::*;

    localparam int unsigned N   = HAR_IMG_SIZE;
    localparam int unsigned M   = HAR_M;
    localparam int unsigned IW  = 24;
    localparam int unsigned N2  = 8;
    localparam int          SH1 = 8;
    localparam int          SH2 = 4;

    typedef struct {
        logic signed [IW-1:0] data;
        bit                   last;
    } beat_t;

    typedef struct {
        logic signed [IW-1:0] data;
        longint               exp8;
        longint               exp4;
        bit                   sat4;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 clear = 1'b0, s_valid = 1'b0, s_last = 1'b0, v_ack = 1'b0;
    logic signed [IW-1:0] s_data = '0;
    logic                 s_ready, V_valid, frame_err;
    logic signed [M:0]    image [N];
    logic [7:0]           sat_cnt;

    logic                 clear2 = 1'b0, s_valid2 = 1'b0, s_last2 = 1'b0, v_ack2 = 1'b0;
    logic signed [IW-1:0] s_data2 = '0;
    logic                 s_ready2, V_valid2, frame_err2;
    logic signed [M:0]    image2 [N2];
    logic [7:0]           sat_cnt2;

    har_feature_loader #(.IMG_SIZE(N), .M(M), .IN_W(IW), .SHIFT(SH1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .image(image), .V_valid(V_valid), .v_ack(v_ack),
        .sat_cnt(sat_cnt), .frame_err(frame_err)
    );

    har_feature_loader #(.IMG_SIZE(N2), .M(M), .IN_W(IW), .SHIFT(SH2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear2), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data2), .s_last(s_last2), .image(image2), .V_valid(V_valid2), .v_ack(v_ack2),
        .sat_cnt(sat_cnt2), .frame_err(frame_err2)
    );

    int     checks   = 0;
    int     failures = 0;
    beat_t  tx_q[$];
    vec_t   vecs[N2];
    longint exp_img [N];
    int     exp_sat;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference quantizer: floor(d / 2^shift) clamped to [-2^m, 2^m-1].
    function automatic longint quant(input longint d, input int shift, input int m);
        longint t, hi, lo;
        t  = d >>> shift;
        hi = (longint'(1) <<< m) - 1;
        lo = -(longint'(1) <<< m);
        if (t > hi) return hi;
        if (t < lo) return lo;
        return t;
    endfunction

    function automatic logic signed [IW-1:0] rnd();
        return IW'($urandom);
    endfunction

    task automatic model_frame(input int base);
        exp_sat = 0;
        for (int i = 0; i < int'(N); i++) begin
            longint d;
            d          = longint'(tx_q[base + i].data);
            exp_img[i] = quant(d, SH1, M);
            if (exp_img[i] != (d >>> SH1) && exp_sat < 255) exp_sat++;
        end
    endtask

    function automatic int img_mism();
        int n = 0;
        for (int i = 0; i < int'(N); i++) if (longint'(image[i]) != exp_img[i]) n++;
        return n;
    endfunction

    function automatic int img_nonzero();
        int n = 0;
        for (int i = 0; i < int'(N); i++) if (image[i] != '0) n++;
        return n;
    endfunction

    task automatic queue_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) tx_q.push_back('{data: rnd(), last: (i == last_at)});
    endtask

    // Drive every queued beat, waiting (bounded) for s_ready; optionally ack a held frame
    // on its third visible cycle.
    task automatic drive_beats(input bit auto_ack);
        int hold_cyc = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            int wait_cyc = 0;
            s_valid = 1'b1;
            s_data  = tx_q[i].data;
            s_last  = tx_q[i].last;
            while (!s_ready) begin
                if (V_valid) hold_cyc++;
                v_ack = auto_ack && (hold_cyc == 3);
                @(posedge clk);
                #1;
                v_ack = 1'b0;
                wait_cyc++;
                if (wait_cyc > 200) begin
                    check("s_ready_timeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
            end
            hold_cyc = 0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic ack1();
        v_ack = 1'b1;
        @(posedge clk);
        #1;
        v_ack = 1'b0;
    endtask

    task automatic send_dut2(input int sat_expected, input bit use_table);
        int sat_m = 0;
        for (int i = 0; i < int'(N2); i++) begin
            logic signed [IW-1:0] d;
            d = use_table ? vecs[i].data : rnd();
            check("dut2_ready", longint'(s_ready2), 1);
            s_valid2 = 1'b1;
            s_data2  = d;
            s_last2  = (i == int'(N2) - 1);
            @(posedge clk);
            #1;
            if (use_table) begin
                check($sformatf("dut2_tab%0d", i), longint'(image2[i]), vecs[i].exp4);
            end else begin
                check($sformatf("dut2_rnd%0d", i), longint'(image2[i]), quant(d, SH2, M));
            end
            if (quant(d, SH2, M) != (longint'(d) >>> SH2)) sat_m++;
        end
        s_valid2 = 1'b0;
        s_last2  = 1'b0;
        check("dut2_vvalid", longint'(V_valid2), 1);
        check("dut2_sat_cnt", longint'(sat_cnt2), use_table ? longint'(sat_expected) : sat_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0;
        vecs[0] = '{data: 24'sh7FFFFF, exp8: 32767,  exp4: 32767,  sat4: 1'b1};
        vecs[1] = '{data: 24'sh800000, exp8: -32768, exp4: -32768, sat4: 1'b1};
        vecs[2] = '{data: 24'sh00FF80, exp8: 255,    exp4: 4088,   sat4: 1'b0};
        vecs[3] = '{data: 24'shFFFFFF, exp8: -1,     exp4: -1,     sat4: 1'b0};
        vecs[4] = '{data: 24'sh07FFF0, exp8: 2047,   exp4: 32767,  sat4: 1'b0};
        vecs[5] = '{data: 24'sh080000, exp8: 2048,   exp4: 32767,  sat4: 1'b1};
        vecs[6] = '{data: 24'shF7FFF0, exp8: -2049,  exp4: -32768, sat4: 1'b1};
        vecs[7] = '{data: 24'shF80000, exp8: -2048,  exp4: -32768, sat4: 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", longint'(s_ready), 0);
        check("rst_vvalid", longint'(V_valid), 0);
        check("rst_sat_cnt", longint'(sat_cnt), 0);
        check("rst_frame_err", longint'(frame_err), 0);
        check("rst_image_zero", img_nonzero(), 0);
        rst = 1'b1;
        #1;
        check("post_rst_s_ready", longint'(s_ready), 1);

        // Ramp frame: image[i] = i, one-cycle latency on V_valid, ack handshake.
        tx_q.delete();
        for (int i = 0; i < int'(N) - 1; i++) tx_q.push_back('{data: IW'(i << 8), last: 1'b0});
        drive_beats(1'b0);
        check("ramp_vvalid_early", longint'(V_valid), 0);
        tx_q.delete();
        tx_q.push_back('{data: IW'((N - 1) << 8), last: 1'b1});
        drive_beats(1'b0);
        check("ramp_vvalid", longint'(V_valid), 1);
        check("ramp_s_ready", longint'(s_ready), 0);
        check("ramp_sat_cnt", longint'(sat_cnt), 0);
        begin
            int bad = 0;
            for (int i = 0; i < int'(N); i++) if (longint'(image[i]) != i) bad++;
            check("ramp_image", bad, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("hold_persist", longint'(V_valid), 1);
        ack1();
        check("ack_vvalid", longint'(V_valid), 0);
        check("ack_s_ready", longint'(s_ready), 1);

        // Vector table followed by random fill.
        tx_q.delete();
        for (int i = 0; i < int'(N2); i++) tx_q.push_back('{data: vecs[i].data, last: 1'b0});
        queue_frame(int'(N - N2), int'(N - N2) - 1);
        drive_beats(1'b0);
        model_frame(0);
        for (int i = 0; i < int'(N2); i++) begin
            check($sformatf("tab%0d", i), longint'(image[i]), vecs[i].exp8);
        end
        check("tab_frame_model", img_mism(), 0);
        check("tab_sat_cnt", longint'(sat_cnt), exp_sat);
        ack1();

        // Clamping instance: table frame, then clear together with v_ack, then random frame.
        begin
            int s = 0;
            for (int i = 0; i < int'(N2); i++) s += int'(vecs[i].sat4);
            send_dut2(s, 1'b1);
        end
        clear2 = 1'b1;
        v_ack2 = 1'b1;
        @(posedge clk);
        #1;
        clear2 = 1'b0;
        v_ack2 = 1'b0;
        check("clr_vvalid", longint'(V_valid2), 0);
        check("clr_s_ready", longint'(s_ready2), 1);
        check("clr_sat_cnt", longint'(sat_cnt2), 0);
        send_dut2(0, 1'b0);

        // Continuous s_valid over two frames with a delayed ack.
        tx_q.delete();
        queue_frame(int'(N), int'(N) - 1);
        queue_frame(int'(N), int'(N) - 1);
        t0 = longint'($time);
        drive_beats(1'b1);
        check("b2b_cycles", (longint'($time) - t0) / 10, longint'(2 * N + 3));
        check("b2b_vvalid", longint'(V_valid), 1);
        model_frame(int'(N));
        check("b2b_frame2", img_mism(), 0);
        ack1();

`ifdef HAR_LOADER_LEN_CHECK_EN
        tx_q.delete();
        queue_frame(41, 40);
        drive_beats(1'b0);
        check("early_err", longint'(frame_err), 1);
        check("early_vvalid", longint'(V_valid), 0);
        @(posedge clk);
        #1;
        check("early_err_pulse", longint'(frame_err), 0);
        tx_q.delete();
        queue_frame(int'(N), int'(N) - 1);
        drive_beats(1'b0);
        model_frame(0);
        check("early_next_vvalid", longint'(V_valid), 1);
        check("early_next_frame", img_mism(), 0);
        ack1();
        tx_q.delete();
        queue_frame(int'(N), -1);
        drive_beats(1'b0);
        check("miss_err", longint'(frame_err), 1);
        check("miss_vvalid", longint'(V_valid), 0);
        check("drain_s_ready", longint'(s_ready), 1);
        tx_q.delete();
        queue_frame(3, 2);
        drive_beats(1'b0);
        check("drain_vvalid", longint'(V_valid), 0);
        tx_q.delete();
        queue_frame(int'(N), int'(N) - 1);
        drive_beats(1'b0);
        model_frame(0);
        check("drain_next_vvalid", longint'(V_valid), 1);
        check("drain_next_frame", img_mism(), 0);
        ack1();
`else
        tx_q.delete();
        queue_frame(int'(N), 40);
        drive_beats(1'b0);
        model_frame(0);
        check("nolen_vvalid", longint'(V_valid), 1);
        check("nolen_err", longint'(frame_err), 0);
        check("nolen_frame", img_mism(), 0);
        ack1();
`endif

        // Asynchronous reset in the middle of a frame.
        tx_q.delete();
        queue_frame(50, -1);
        drive_beats(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_vvalid", longint'(V_valid), 0);
        check("mid_rst_s_ready", longint'(s_ready), 0);
        check("mid_rst_image", img_nonzero(), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_release", longint'(s_ready), 1);
        tx_q.delete();
        queue_frame(int'(N), int'(N) - 1);
        drive_beats(1'b0);
        model_frame(0);
        check("after_rst_vvalid", longint'(V_valid), 1);
        check("after_rst_frame", img_mism(), 0);

        // clear together with v_ack while holding.
        clear = 1'b1;
        v_ack = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        v_ack = 1'b0;
        check("clr1_vvalid", longint'(V_valid), 0);
        check("clr1_s_ready", longint'(s_ready), 1);
        check("clr1_sat_cnt", longint'(sat_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
